// File: rtl/led_tester_core.sv
// LED tester state/command/report core: holds an N_LED-bit LED state driven by
// UART commands and key pulses, and reports it as framed 6-bit chunks to uart_tx.
module led_tester_core #(
    parameter int               N_LED         = 6,
    parameter bit               AUTO_REPORT   = 1'b1,
    parameter logic [N_LED-1:0] RESET_PATTERN = '0
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [7:0]       in_uart,
    input  logic             in_uart_en,
    input  logic             in_key_switch,
    output logic [N_LED-1:0] out_mem,
    output logic [5:0]       o_cursor,
    output logic             o_cmd_err,
    output logic             o_tx_start,
    output logic [7:0]       o_tx_data,
    input  logic             in_tx_busy,
    input  logic             in_tx_done,
    output logic             o_report_busy
);

    localparam int         NB       = (N_LED + 5) / 6;
    localparam int         SW       = NB * 6;
    localparam logic [5:0] LAST_K   = 6'(NB - 1);
    localparam logic [5:0] LAST_LED = 6'(N_LED - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_WAIT = 3'd3,
        ST_NEXT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [N_LED-1:0] mem_q, mem_d;
    logic [5:0]       cursor_q, cursor_d;
    logic             cmd_err_q, cmd_err_d;
    logic             key_pend_q, key_pend_d;
    logic             rep_pend_q, rep_pend_d;
    logic [SW-1:0]    snap_q, snap_d;
    logic [5:0]       k_q, k_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             busy_q, busy_d;

    logic [1:0]       op_s;
    logic [5:0]       idx_s;
    logic             query_s;
    logic             req_s;
    logic [5:0]       chunk_s;

    assign op_s  = in_uart[7:6];
    assign idx_s = in_uart[5:0];

    // Command/key datapath: UART wins the cycle, a colliding key waits one cycle.
    always_comb begin
        mem_d      = mem_q;
        cursor_d   = cursor_q;
        cmd_err_d  = 1'b0;
        key_pend_d = key_pend_q;
        query_s    = 1'b0;
        if (in_uart_en) begin
            key_pend_d = key_pend_q | in_key_switch;
            case (op_s)
                2'b11: begin
                    if (idx_s == 6'h00) begin
                        query_s = 1'b1;
                    end else if (idx_s == 6'h3F) begin
                        mem_d = RESET_PATTERN;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: begin
                    if ({1'b0, idx_s} >= 7'(N_LED)) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < N_LED; i++) begin
                            mem_d[i] = (idx_s == 6'(i)) ?
                                       ((op_s == 2'b10) ? ~mem_q[i] : op_s[0]) : mem_q[i];
                        end
                    end
                end
            endcase
        end else if (key_pend_q || in_key_switch) begin
            key_pend_d = 1'b0;
            for (int i = 0; i < N_LED; i++) begin
                mem_d[i] = (cursor_q == 6'(i)) ? ~mem_q[i] : mem_q[i];
            end
            cursor_d = (cursor_q == LAST_LED) ? 6'd0 : cursor_q + 6'd1;
        end else begin
            key_pend_d = key_pend_q;
        end
    end

    assign req_s = query_s | (AUTO_REPORT & (mem_d != mem_q));

    // Select the 6-bit chunk of the snapshot addressed by k.
    always_comb begin
        chunk_s = 6'd0;
        for (int i = 0; i < NB; i++) begin
            chunk_s = (k_q == 6'(i)) ? snap_q[i*6 +: 6] : chunk_s;
        end
    end

    // Report FSM next-state and outputs.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        k_d        = k_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        rep_pend_d = rep_pend_q | (req_s & (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                snap_d            = '0;
                snap_d[N_LED-1:0] = mem_q;
                k_d               = 6'd0;
                busy_d            = 1'b1;
                state_d           = ST_ARM;
            end
            ST_ARM: begin
                if (!in_tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = {(k_q == LAST_K), 1'b0, chunk_s};
                    state_d    = ST_WAIT;
                end else begin
                    state_d    = ST_ARM;
                end
            end
            ST_WAIT: begin
                if (in_tx_done) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_NEXT: begin
                if (k_q != LAST_K) begin
                    k_d     = k_q + 6'd1;
                    state_d = ST_ARM;
                end else if (rep_pend_q || req_s) begin
                    rep_pend_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any report in flight.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q    <= ST_IDLE;
            mem_q      <= RESET_PATTERN;
            cursor_q   <= 6'd0;
            cmd_err_q  <= 1'b0;
            key_pend_q <= 1'b0;
            rep_pend_q <= 1'b0;
            snap_q     <= '0;
            k_q        <= 6'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            cursor_q   <= cursor_d;
            cmd_err_q  <= cmd_err_d;
            key_pend_q <= key_pend_d;
            rep_pend_q <= rep_pend_d;
            snap_q     <= snap_d;
            k_q        <= k_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign out_mem       = mem_q;
    assign o_cursor      = cursor_q;
    assign o_cmd_err     = cmd_err_q;
    assign o_tx_start    = tx_start_q;
    assign o_tx_data     = tx_data_q;
    assign o_report_busy = busy_q;

endmodule

// File: tb/tb_led_tester_core.sv
// Directed bench for led_tester_core: a 6-LED auto-reporting instance and a
// 16-LED query-only instance, each with a simple uart_tx responder.
module tb_led_tester_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] uart_a = 8'h00;
    logic       en_a   = 1'b0;
    logic       key_a  = 1'b0;
    logic [5:0] mem_a, cursor_a;
    logic       err_a, start_a, rbusy_a, txbusy_a, txdone_a;
    logic [7:0] data_a;
    int         cnt_a, blen_a = 4, viol_a = 0;
    logic [7:0] q_a[$];

    logic [7:0]  uart_b = 8'h00;
    logic        en_b   = 1'b0;
    logic        key_b  = 1'b0;
    logic [15:0] mem_b;
    logic [5:0]  cursor_b;
    logic        err_b, start_b, rbusy_b, txbusy_b, txdone_b;
    logic [7:0]  data_b;
    int          cnt_b, blen_b = 3, viol_b = 0;
    logic [7:0]  q_b[$];

    int base;

    led_tester_core #(.N_LED(6), .AUTO_REPORT(1'b1), .RESET_PATTERN(6'b101010)) dut_a (
        .in_clk(clk), .in_rst(rst_n), .in_uart(uart_a), .in_uart_en(en_a),
        .in_key_switch(key_a), .out_mem(mem_a), .o_cursor(cursor_a), .o_cmd_err(err_a),
        .o_tx_start(start_a), .o_tx_data(data_a), .in_tx_busy(txbusy_a),
        .in_tx_done(txdone_a), .o_report_busy(rbusy_a)
    );

    led_tester_core #(.N_LED(16), .AUTO_REPORT(1'b0), .RESET_PATTERN(16'h0000)) dut_b (
        .in_clk(clk), .in_rst(rst_n), .in_uart(uart_b), .in_uart_en(en_b),
        .in_key_switch(key_b), .out_mem(mem_b), .o_cursor(cursor_b), .o_cmd_err(err_b),
        .o_tx_start(start_b), .o_tx_data(data_b), .in_tx_busy(txbusy_b),
        .in_tx_done(txdone_b), .o_report_busy(rbusy_b)
    );

    // uart_tx responder for instance A: records bytes, busy for blen_a+1 cycles, then done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txbusy_a <= 1'b0; txdone_a <= 1'b0; cnt_a <= 0;
        end else begin
            txdone_a <= 1'b0;
            if (start_a) begin
                if (txbusy_a) viol_a <= viol_a + 1;
                q_a.push_back(data_a);
                txbusy_a <= 1'b1; cnt_a <= blen_a;
            end else if (txbusy_a) begin
                if (cnt_a == 0) begin txbusy_a <= 1'b0; txdone_a <= 1'b1; end
                else cnt_a <= cnt_a - 1;
            end
        end
    end

    // uart_tx responder for instance B.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txbusy_b <= 1'b0; txdone_b <= 1'b0; cnt_b <= 0;
        end else begin
            txdone_b <= 1'b0;
            if (start_b) begin
                if (txbusy_b) viol_b <= viol_b + 1;
                q_b.push_back(data_b);
                txbusy_b <= 1'b1; cnt_b <= blen_b;
            end else if (txbusy_b) begin
                if (cnt_b == 0) begin txbusy_b <= 1'b0; txdone_b <= 1'b1; end
                else cnt_b <= cnt_b - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] b);
        uart_a = b; en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        uart_b = b; en_b = 1'b1;
        @(negedge clk);
        en_b = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (rbusy_a === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk(tag, 64'(rbusy_a), 64'd0);
    endtask

    task automatic wait_idle_b(input string tag);
        int n = 0;
        while (rbusy_b === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk(tag, 64'(rbusy_b), 64'd0);
    endtask

    initial begin
        // Reset values
        tick(3);
        chk("rst_mem_a",    64'(mem_a),    64'h2A);
        chk("rst_cursor_a", 64'(cursor_a), 64'h0);
        chk("rst_err_a",    64'(err_a),    64'h0);
        chk("rst_start_a",  64'(start_a),  64'h0);
        chk("rst_data_a",   64'(data_a),   64'h0);
        chk("rst_rbusy_a",  64'(rbusy_a),  64'h0);
        chk("rst_mem_b",    64'(mem_b),    64'h0);
        chk("rst_cursor_b", 64'(cursor_b), 64'h0);
        rst_n = 1'b1;
        tick(1);

        // Reset mid-report
        send_a(8'hC0);
        chk("query_busy", 64'(rbusy_a), 64'h1);
        chk("query_mem",  64'(mem_a),   64'h2A);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem",   64'(mem_a),   64'h2A);
        chk("midrst_start", 64'(start_a), 64'h0);
        chk("midrst_rbusy", 64'(rbusy_a), 64'h0);
        tick(1);
        rst_n = 1'b1;
        base = q_a.size();
        tick(40);
        chk("postrst_bytes", 64'(q_a.size()), 64'(base));
        chk("postrst_rbusy", 64'(rbusy_a),    64'h0);

        // Bring A to 0, then set / toggle with auto-report
        send_a(8'h01); chk("clr1", 64'(mem_a), 64'h28); wait_idle_a("idle_clr1");
        send_a(8'h03); chk("clr3", 64'(mem_a), 64'h20); wait_idle_a("idle_clr3");
        send_a(8'h05); chk("clr5", 64'(mem_a), 64'h00); wait_idle_a("idle_clr5");
        base = q_a.size();
        send_a(8'h43);
        chk("set3_mem", 64'(mem_a), 64'h08);
        wait_idle_a("idle_set3");
        chk("set3_nbytes", 64'(q_a.size()), 64'(base + 1));
        chk("set3_byte",   64'(q_a[base]),  64'h88);
        base = q_a.size();
        send_a(8'h83);
        chk("tgl3_mem", 64'(mem_a), 64'h00);
        wait_idle_a("idle_tgl3");
        chk("tgl3_nbytes", 64'(q_a.size()), 64'(base + 1));
        chk("tgl3_byte",   64'(q_a[base]),  64'h80);
        base = q_a.size();
        send_a(8'h03);
        chk("nochg_mem",   64'(mem_a),   64'h00);
        chk("nochg_rbusy", 64'(rbusy_a), 64'h0);
        tick(10);
        chk("nochg_bytes", 64'(q_a.size()), 64'(base));

        // Rejected commands
        base = q_a.size();
        send_a(8'h47);
        chk("rej47_err", 64'(err_a), 64'h1);
        chk("rej47_mem", 64'(mem_a), 64'h00);
        tick(1);
        chk("rej47_err_end", 64'(err_a), 64'h0);
        send_a(8'hC5);
        chk("rejC5_err", 64'(err_a), 64'h1);
        chk("rejC5_mem", 64'(mem_a), 64'h00);
        tick(1);
        chk("rejC5_err_end", 64'(err_a), 64'h0);
        tick(10);
        chk("rej_bytes", 64'(q_a.size()), 64'(base));
        chk("rej_rbusy", 64'(rbusy_a),    64'h0);

        // UART/key collision, then cursor wrap
        uart_a = 8'h40; en_a = 1'b1; key_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0; key_a = 1'b0;
        chk("col_mem0",    64'(mem_a),    64'h01);
        chk("col_cursor0", 64'(cursor_a), 64'h0);
        tick(1);
        chk("col_mem1",    64'(mem_a),    64'h00);
        chk("col_cursor1", 64'(cursor_a), 64'h1);
        for (int i = 0; i < 6; i++) begin
            key_a = 1'b1; @(negedge clk);
            key_a = 1'b0; @(negedge clk);
        end
        chk("wrap_cursor", 64'(cursor_a), 64'h1);
        chk("wrap_mem",    64'(mem_a),    64'h3F);
        wait_idle_a("idle_wrap");
        chk("wrap_last_byte", 64'(q_a[q_a.size()-1]), 64'hBF);

        // Coalescing under a long busy
        blen_a = 20;
        base = q_a.size();
        send_a(8'hFF); chk("coal_clrall", 64'(mem_a), 64'h2A);
        tick(2);
        send_a(8'h00); chk("coal_m0", 64'(mem_a), 64'h2A);
        send_a(8'h01); chk("coal_m1", 64'(mem_a), 64'h28);
        send_a(8'h44); chk("coal_m2", 64'(mem_a), 64'h38);
        send_a(8'h80); chk("coal_m3", 64'(mem_a), 64'h39);
        wait_idle_a("idle_coal");
        chk("coal_nbytes", 64'(q_a.size()), 64'(base + 2));
        chk("coal_byte0",  64'(q_a[base]),     64'hAA);
        chk("coal_byte1",  64'(q_a[base + 1]), 64'hB9);
        chk("viol_a", 64'(viol_a), 64'd0);
        blen_a = 4;

        // Wide instance: rejection at the N_LED boundary, then a 3-byte frame
        send_b(8'h50);
        chk("rej50_err", 64'(err_b), 64'h1);
        chk("rej50_mem", 64'(mem_b), 64'h0);
        for (int i = 0; i < 16; i++) send_b(8'h40 + 8'(i));
        chk("wide_mem",   64'(mem_b),   64'hFFFF);
        chk("wide_noaut", 64'(rbusy_b), 64'h0);
        base = q_b.size();
        send_b(8'hC0);
        chk("wide_busy", 64'(rbusy_b), 64'h1);
        wait_idle_b("idle_wide");
        chk("wide_nbytes", 64'(q_b.size()), 64'(base + 3));
        chk("wide_byte0",  64'(q_b[base]),     64'h3F);
        chk("wide_byte1",  64'(q_b[base + 1]), 64'h3F);
        chk("wide_byte2",  64'(q_b[base + 2]), 64'h8F);
        chk("viol_b", 64'(viol_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
